mem_stage_ctrl: RTL

- Memory-stage initiator between the EXE/MEM pipeline register and the word-wide data memory.
- Accepts one load or store per instruction and drives the memory's read-enable, write-enable, address and write-data inputs.
- Holds the pipeline frozen for a fixed number of wait states, then captures load data for write-back.
- Models a multi-cycle data memory without changing the memory itself.

---
 rtl/mem_stage_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage initiator: turns one EXE/MEM load/store into a fixed-latency data-memory access.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of being silently aligned.
module mem_stage_ctrl #(
    parameter int WORD_LEN    = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_BASE   = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_R_EN,
    input  logic                MEM_W_EN,
    input  logic [WORD_LEN-1:0] address,
    input  logic [WORD_LEN-1:0] ST_val,
    input  logic [WORD_LEN-1:0] mem_dataOut,
    output logic                mem_readEn,
    output logic                mem_writeEn,
    output logic [WORD_LEN-1:0] mem_address,
    output logic [WORD_LEN-1:0] mem_dataIn,
    output logic                freeze,
    output logic [WORD_LEN-1:0] dataOut,
    output logic                dataValid,
    output logic                addr_err
);

    localparam logic [3:0]          WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [WORD_LEN-1:0] BASE      = WORD_LEN'(DATA_BASE);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state, state_nxt;
    logic [3:0]          counter, counter_nxt;
    logic [WORD_LEN-1:0] lat_addr, lat_data;
    logic                lat_store, lat_fault;
    logic                req, req_fault;

    assign req = MEM_R_EN | MEM_W_EN;

`ifdef MEM_MISALIGN_TRAP_EN
    assign req_fault = (address < BASE) || (address[1:0] != 2'b00);
`else
    assign req_fault = (address < BASE);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= 4'd0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_store <= 1'b0;
            lat_fault <= 1'b0;
            dataOut   <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            if (state == IDLE && req) begin
                // Address is stored pre-aligned; a simultaneous read+write is a store.
                lat_addr  <= {address[WORD_LEN-1:2], 2'b00};
                lat_data  <= ST_val;
                lat_store <= MEM_W_EN;
                lat_fault <= req_fault;
            end
            if (state == ACCESS && counter == 4'd0 && !lat_store)
                dataOut <= lat_fault ? '0 : mem_dataOut;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        mem_readEn  = 1'b0;
        mem_writeEn = 1'b0;
        mem_address = '0;
        mem_dataIn  = '0;
        freeze      = 1'b0;
        dataValid   = 1'b0;
        addr_err    = 1'b0;
        case (state)
            IDLE: begin
                // Freeze in the detect cycle so the pipeline holds this instruction.
                if (req) begin
                    freeze      = 1'b1;
                    state_nxt   = ACCESS;
                    counter_nxt = WAIT_INIT;
                end
            end
            ACCESS: begin
                freeze      = 1'b1;
                mem_address = lat_addr;
                mem_dataIn  = lat_data;
                mem_readEn  = !lat_store;
                if (counter == 4'd0) begin
                    // Single write edge per store, suppressed for faulted accesses.
                    mem_writeEn = lat_store && !lat_fault;
                    state_nxt   = DONE;
                end else begin
                    counter_nxt = counter - 4'd1;
                end
            end
            DONE: begin
                dataValid = 1'b1;
                addr_err  = lat_fault;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
